// File: rtl/keypad_b3_if.sv
// Event handshake between the keypad scanner (master) and the CPU I/O register block (slave).
// The master raises key_valid with key_code; the slave answers with a one-cycle key_ack.
interface keypad_b3_if;
  logic       key_ack;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       overrun;

  modport master (input key_ack, output key_code, output key_valid, output key_down, output overrun);
  modport slave  (output key_ack, input key_code, input key_valid, input key_down, input overrun);
endinterface

// File: rtl/keypad_b3.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, samples and debounces the rows,
// and posts single-key presses as hex codes over a valid/ack handshake.
module keypad_b3 #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    row,
  output logic [3:0]    col,
  keypad_b3_if.master   kif
);

  localparam int             DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_MAX     = 4'(DEBOUNCE_COUNT);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_colidx;
  logic [3:0]    r_col;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [15:0]   r_raw;
  logic [15:0]   r_cand;
  logic [15:0]   r_deb;
  logic [15:0]   r_deb_prev;
  logic [3:0]    r_cnt;
  logic [3:0]    r_code;
  logic          r_valid;
  logic          r_down;
  logic          r_overrun;

  logic          w_last;
  logic          w_scan_done;
  logic [15:0]   w_raw_next;
  logic [15:0]   w_cand_next;
  logic [15:0]   w_deb_next;
  logic [3:0]    w_cnt_next;
  logic          w_event;

  function automatic logic is_onehot(input logic [15:0] m);
    return (m != 16'd0) && ((m & (m - 16'd1)) == 16'd0);
  endfunction

  // Bit index is 4*column + row; the table follows the PmodKYPD legend.
  function automatic logic [3:0] map_code(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) idx = 4'(i);
    end
    case (idx)
      4'd0:    return 4'h1;
      4'd1:    return 4'h4;
      4'd2:    return 4'h7;
      4'd3:    return 4'h0;
      4'd4:    return 4'h2;
      4'd5:    return 4'h5;
      4'd6:    return 4'h8;
      4'd7:    return 4'hF;
      4'd8:    return 4'h3;
      4'd9:    return 4'h6;
      4'd10:   return 4'h9;
      4'd11:   return 4'hE;
      4'd12:   return 4'hA;
      4'd13:   return 4'hB;
      4'd14:   return 4'hC;
      4'd15:   return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  assign w_last      = (r_dwell == DWELL_LAST);
  assign w_scan_done = w_last && (r_colidx == 2'd3);
  // Fires for exactly one cycle, the cycle after the debounced map leaves zero for a single key.
  assign w_event     = (r_deb_prev == 16'd0) && is_onehot(r_deb);

  // Raw map including the column being captured this cycle, so a full-scan compare sees all 16 keys.
  always_comb begin
    w_raw_next = r_raw;
    if (w_last) begin
      w_raw_next[{r_colidx, 2'b00} +: 4] = ~r_sync2;
    end else begin
      w_raw_next = r_raw;
    end
  end

  // Debounce update evaluated at each full-scan completion.
  always_comb begin
    w_cand_next = r_cand;
    w_cnt_next  = r_cnt;
    w_deb_next  = r_deb;
    if (w_scan_done) begin
      if (w_raw_next == r_cand) begin
        w_cnt_next = (r_cnt != DB_MAX) ? (r_cnt + 4'd1) : r_cnt;
      end else begin
        w_cand_next = w_raw_next;
        w_cnt_next  = 4'd1;
      end
      if (w_cnt_next == DB_MAX) begin
        w_deb_next = w_cand_next;
      end else begin
        w_deb_next = r_deb;
      end
    end else begin
      w_deb_next = r_deb;
    end
  end

  // Column dwell counter and rotating active-low column drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell  <= '0;
      r_colidx <= 2'd0;
      r_col    <= 4'b1110;
    end else if (w_last) begin
      r_dwell  <= '0;
      r_colidx <= r_colidx + 2'd1;
      r_col    <= {r_col[2:0], r_col[3]};
    end else begin
      r_dwell  <= r_dwell + DW'(1);
    end
  end

  // Row synchronizer, raw capture and debounced key map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
      r_raw      <= 16'd0;
      r_cand     <= 16'd0;
      r_cnt      <= 4'd0;
      r_deb      <= 16'd0;
      r_deb_prev <= 16'd0;
      r_down     <= 1'b0;
    end else begin
      r_sync1    <= row;
      r_sync2    <= r_sync1;
      r_raw      <= w_raw_next;
      r_cand     <= w_cand_next;
      r_cnt      <= w_cnt_next;
      r_deb      <= w_deb_next;
      r_deb_prev <= r_deb;
      r_down     <= (r_deb != 16'd0);
    end
  end

  // Event handshake: a coincident ack lets the new event replace the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code    <= 4'h0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_event) begin
      if (!r_valid || kif.key_ack) begin
        r_code  <= map_code(r_deb);
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (kif.key_ack && r_valid) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign col           = r_col;
  assign kif.key_code  = r_code;
  assign kif.key_valid = r_valid;
  assign kif.key_down  = r_down;
  assign kif.overrun   = r_overrun;

endmodule
